// File: rtl/sram_rr_arbiter_if.sv
`default_nettype none
// ==================================================================
// sram_rr_if : one requester's request/response channel to the arbiter
// Revision 1.0
// ==================================================================
interface sram_rr_if #(
  parameter int w  = 8,
  parameter int aw = 4
) ();
  logic          valid;
  logic          ready;
  logic          we;
  logic [aw-1:0] addr;
  logic [w-1:0]  wdata;
  logic          rvalid;
  logic [w-1:0]  rdata;

  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ==================================================================
// sram_rr_arbiter : clears a 1-port SRAM, then round-robins two requesters
// Revision 1.0
// ==================================================================
module sram_rr_arbiter #(
  parameter int w = 8,
  parameter int d = 16,
  localparam int aw = (d > 1) ? $clog2(d) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sram_rr_if.slave           p0,
  sram_rr_if.slave           p1,
  output logic               mem_we,
  output logic [aw-1:0]      mem_addr,
  output logic [w-1:0]       mem_wdata,
  input  wire logic [w-1:0]  mem_rdata,
  output logic               init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [aw-1:0] c_last_addr = aw'(d - 1);

  state_t        r_state,      w_state_nxt;
  logic [aw-1:0] r_clr_cnt,    w_clr_cnt_nxt;
  logic          r_last_grant, w_last_grant_nxt;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic          w_gnt0;
  logic          w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_clr_cnt    <= '0;
      r_last_grant <= 1'b1;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_rvalid0    <= w_gnt0 & ~p0.we;
      r_rvalid1    <= w_gnt1 & ~p1.we;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_clr_cnt_nxt    = r_clr_cnt;
    w_last_grant_nxt = r_last_grant;
    w_gnt0           = 1'b0;
    w_gnt1           = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;

    case (r_state)
      ST_INIT: begin
        mem_we        = 1'b1;
        mem_addr      = r_clr_cnt;
        w_clr_cnt_nxt = r_clr_cnt + aw'(1);
        if (r_clr_cnt == c_last_addr) begin
          w_state_nxt   = ST_RUN;
          w_clr_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        // On contention the port that did not win last time gets the slot.
        if (p0.valid && (!p1.valid || r_last_grant)) begin
          w_gnt0 = 1'b1;
        end else if (p1.valid) begin
          w_gnt1 = 1'b1;
        end

        if (w_gnt0) begin
          mem_we           = p0.we;
          mem_addr         = p0.addr;
          mem_wdata        = p0.wdata;
          w_last_grant_nxt = 1'b0;
        end else if (w_gnt1) begin
          mem_we           = p1.we;
          mem_addr         = p1.addr;
          mem_wdata        = p1.wdata;
          w_last_grant_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase

    // The state register is forced to INIT during reset; keep the SRAM quiet too.
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  assign p0.ready  = w_gnt0;
  assign p1.ready  = w_gnt1;
  assign p0.rvalid = r_rvalid0;
  assign p1.rvalid = r_rvalid1;
  assign p0.rdata  = mem_rdata;
  assign p1.rdata  = mem_rdata;
  assign init_done = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ==================================================================
// tb_sram_rr_arbiter : random + directed scoreboard bench for sram_rr_arbiter
// Revision 1.0
// ==================================================================
module tb_sram_rr_arbiter;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          init_done;

  always #5 clk = ~clk;

  sram_rr_if #(.w(W), .aw(AW)) p0_if ();
  sram_rr_if #(.w(W), .aw(AW)) p1_if ();

  sram_rr_arbiter #(.w(W), .d(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0        (p0_if.slave),
    .p1        (p1_if.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .init_done (init_done)
  );

  // Single-port synchronous-read SRAM
  logic [W-1:0] sram [D];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] ref_mem [D];
  int           ref_last = 1;
  exp_t         q0[$];
  exp_t         q1[$];
  logic         acc0, acc1;
  logic         got0, got1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle each port's rvalid must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      chk("p0_rvalid", p0_if.rvalid, 1);
      chk("p0_rdata", p0_if.rdata, e.data);
    end else begin
      chk("p0_rvalid_spurious", p0_if.rvalid, 0);
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      chk("p1_rvalid", p1_if.rvalid, 1);
      chk("p1_rdata", p1_if.rdata, e.data);
    end else begin
      chk("p1_rvalid_spurious", p1_if.rvalid, 0);
    end
  end

  // One RUN cycle: reference arbitration decides who should win, then the bus is checked.
  task automatic run_cycle();
    int            g;
    logic          we;
    logic [AW-1:0] a;
    logic [W-1:0]  wd;
    exp_t          e;
    @(negedge clk);
    if (p0_if.valid && p1_if.valid) g = (ref_last == 1) ? 0 : 1;
    else if (p0_if.valid)           g = 0;
    else if (p1_if.valid)           g = 1;
    else                            g = -1;
    got0 = p0_if.ready;
    got1 = p1_if.ready;
    chk("p0_ready", got0, (g == 0));
    chk("p1_ready", got1, (g == 1));
    chk("init_done_run", init_done, 1);
    if (g >= 0) begin
      we = (g == 0) ? p0_if.we    : p1_if.we;
      a  = (g == 0) ? p0_if.addr  : p1_if.addr;
      wd = (g == 0) ? p0_if.wdata : p1_if.wdata;
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, a);
      if (we) begin
        chk("mem_wdata", mem_wdata, wd);
        ref_mem[a] = wd;
      end else begin
        e.cyc  = cyc + 1;
        e.data = ref_mem[a];
        if (g == 0) q0.push_back(e); else q1.push_back(e);
      end
      ref_last = g;
    end else begin
      chk("idle_mem_we", mem_we, 0);
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_wdata", mem_wdata, 0);
    end
    acc0 = (g == 0);
    acc1 = (g == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [W-1:0] wd);
    if (p == 0) begin
      p0_if.valid = v; p0_if.we = we; p0_if.addr = a; p0_if.wdata = wd;
    end else begin
      p1_if.valid = v; p1_if.we = we; p1_if.addr = a; p1_if.wdata = wd;
    end
  endtask

  task automatic init_check();
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("init_mem_we", mem_we, 1);
      chk("init_mem_addr", mem_addr, i);
      chk("init_mem_wdata", mem_wdata, 0);
      chk("init_p0_ready", p0_if.ready, 0);
      chk("init_p1_ready", p1_if.ready, 0);
      chk("init_done_low", init_done, 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset now, check the held-reset outputs, release and check the clear sweep.
  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    ref_last = 1;
    set_port(0, 1'b1, 1'b0, 4'd5, 8'h00);
    set_port(1, 1'b1, 1'b1, 4'd6, 8'h11);
    repeat (3) begin
      @(negedge clk);
      chk("rst_p0_ready", p0_if.ready, 0);
      chk("rst_p1_ready", p1_if.ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_init_done", init_done, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_check();
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (!p0_if.valid || acc0)
        set_port(0, ($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), W'($urandom));
      if (!p1_if.valid || acc1)
        set_port(1, ($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), W'($urandom));
      run_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    do_reset();

    // p1 alone: eight back-to-back writes to the upper half
    for (int i = 0; i < 8; i++) begin
      set_port(1, 1'b1, 1'b1, AW'(8 + i), W'($urandom));
      run_cycle();
      chk("p1_alone_ready", got1, 1);
    end
    set_port(1, 1'b0, 1'b0, '0, '0);

    // Sustained contention on never-written addresses: p0 first, then alternate
    set_port(0, 1'b1, 1'b0, 4'd1, 8'h00);
    set_port(1, 1'b1, 1'b0, 4'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("contention_p0", got0, (i % 2 == 0));
      chk("contention_p1", got1, (i % 2 == 1));
    end
    set_port(1, 1'b0, 1'b0, '0, '0);

    // Write then immediate read-back on p0
    set_port(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    run_cycle();
    set_port(0, 1'b1, 1'b0, 4'd3, 8'h00);
    run_cycle();
    chk("rd_after_wr_model", ref_mem[3], 8'hA5);
    set_port(0, 1'b1, 1'b0, 4'd7, 8'h00);
    run_cycle();
    set_port(0, 1'b0, 1'b0, '0, '0);
    run_cycle();
    run_cycle();

    random_cycles(400);

    // Reset right after a p1 read is accepted: its response must never appear
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b0, 4'd3, 8'h00);
    run_cycle();
    chk("pre_reset_p1_grant", got1, 1);
    set_port(1, 1'b0, 1'b0, '0, '0);
    do_reset();

    random_cycles(40);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) run_cycle();
    chk("scoreboard_empty", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
